// File: rtl/flu_wb_arbiter.sv
// Buffered round-robin writeback merge for the FLU result port: one FIFO per
// producer, one scoreboard write per cycle, no output backpressure.
package flu_wb_pkg;
    localparam int unsigned XLEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 3;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;
endpackage

module flu_wb_arbiter #(
    parameter int unsigned NrSrc     = 4,
    parameter int unsigned Depth     = 2,
    parameter int unsigned DataWidth = flu_wb_pkg::XLEN,
    parameter int unsigned IdWidth   = flu_wb_pkg::TRANS_ID_BITS
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    clr_i,
    input  logic                                    flush_i,
    input  logic [NrSrc-1:0]                        src_valid_i,
    output logic [NrSrc-1:0]                        src_ready_o,
    input  logic [NrSrc-1:0][DataWidth-1:0]         src_result_i,
    input  logic [NrSrc-1:0][IdWidth-1:0]           src_trans_id_i,
    input  flu_wb_pkg::exception_t [NrSrc-1:0]      src_exception_i,
    output logic                                    wb_valid_o,
    output logic [DataWidth-1:0]                    wb_result_o,
    output logic [IdWidth-1:0]                      wb_trans_id_o,
    output flu_wb_pkg::exception_t                  wb_exception_o,
    output logic [$clog2(NrSrc)-1:0]                wb_src_o,
    output logic [NrSrc-1:0][$clog2(Depth+1)-1:0]   occupancy_o
);
    localparam int unsigned SrcW = $clog2(NrSrc);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    typedef struct packed {
        logic [DataWidth-1:0]   result;
        logic [IdWidth-1:0]     trans_id;
        flu_wb_pkg::exception_t exception;
    } entry_t;

    entry_t           mem_q  [NrSrc][Depth];
    logic [PtrW-1:0]  rptr_q [NrSrc];
    logic [PtrW-1:0]  wptr_q [NrSrc];
    logic [CntW-1:0]  cnt_q  [NrSrc];
    logic [SrcW-1:0]  last_q;

    logic [NrSrc-1:0] empty, full, push, pop;
    logic [SrcW-1:0]  grant, cand;
    logic             any_req, clear;
    entry_t           head;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign clear       = clr_i | flush_i;
    assign src_ready_o = ~full;
    assign push        = src_valid_i & ~full & {NrSrc{~clear}};

    always_comb begin
        empty = '0;
        full  = '0;
        for (int unsigned i = 0; i < NrSrc; i++) begin
            empty[i]       = (cnt_q[i] == '0);
            full[i]        = (cnt_q[i] == CntW'(Depth));
            occupancy_o[i] = cnt_q[i];
        end
    end

    // Scan last+1 .. last+NrSrc (mod NrSrc); the first non-empty channel wins.
    always_comb begin
        grant   = '0;
        cand    = '0;
        any_req = 1'b0;
        pop     = '0;
        for (int unsigned k = 1; k <= NrSrc; k++) begin
            cand = SrcW'((32'(last_q) + k) % NrSrc);
            if (!any_req && !empty[cand]) begin
                any_req = 1'b1;
                grant   = cand;
            end
        end
        pop[grant] = any_req;
    end

    always_comb begin
        head           = mem_q[grant][rptr_q[grant]];
        wb_valid_o     = any_req;
        wb_result_o    = any_req ? head.result    : '0;
        wb_trans_id_o  = any_req ? head.trans_id  : '0;
        wb_exception_o = any_req ? head.exception : '0;
        wb_src_o       = any_req ? grant          : '0;
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < NrSrc; i++) begin
            if (push[i]) begin
                mem_q[i][wptr_q[i]] <= '{result:    src_result_i[i],
                                         trans_id:  src_trans_id_i[i],
                                         exception: src_exception_i[i]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NrSrc; i++) begin
                rptr_q[i] <= '0;
                wptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            last_q <= SrcW'(NrSrc - 1);
        end else if (clear) begin
            for (int unsigned i = 0; i < NrSrc; i++) begin
                rptr_q[i] <= '0;
                wptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            last_q <= SrcW'(NrSrc - 1);
        end else begin
            for (int unsigned i = 0; i < NrSrc; i++) begin
                if (push[i]) wptr_q[i] <= ptr_inc(wptr_q[i]);
                if (pop[i])  rptr_q[i] <= ptr_inc(rptr_q[i]);
                case ({push[i], pop[i]})
                    2'b10:   cnt_q[i] <= cnt_q[i] + 1'b1;
                    2'b01:   cnt_q[i] <= cnt_q[i] - 1'b1;
                    default: cnt_q[i] <= cnt_q[i];
                endcase
            end
            if (any_req) last_q <= grant;
        end
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     (src_valid_i & ~src_ready_o) == '0);

endmodule

// File: doc/flu_wb_arbiter.md
# flu_wb_arbiter

Parametrised writeback arbiter for the fixed-latency-unit (FLU) result port in the execute stage. It generalises the single-cycle result mux into a buffered, round-robin merge. Up to `NrSrc` result producers (ALU/branch, CSR, multiplier, future units) each push `{result, trans_id, exception}` into a private FIFO of depth `Depth`. A fair arbiter drains one entry per cycle onto the single scoreboard write port, so producers no longer need issue-side collision avoidance.

## Interface
- `NrSrc`, 4: number of producer channels (≥2).
- `Depth`, 2: entries per channel FIFO (≥1, power of two not required).
- `DataWidth`, riscv::XLEN: result width.
- `IdWidth`, TRANS_ID_BITS: scoreboard transaction-ID width.

- `clk_i`  in  1  clock; one clock domain.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `clr_i`  in  1  synchronous clear, active high.
- `flush_i`  in  1  pipeline flush, active high.
- `src_valid_i`  in  NrSrc  producer i presents a result.
- `src_ready_o`  out  NrSrc  channel i FIFO can accept.
- `src_result_i`  in  NrSrc×DataWidth  per-channel result.
- `src_trans_id_i`  in  NrSrc×IdWidth  per-channel scoreboard ID.
- `src_exception_i`  in  NrSrc×exception_t  per-channel exception.
- `wb_valid_o`  out  1  writeback valid.
- `wb_result_o`  out  DataWidth  writeback result.
- `wb_trans_id_o`  out  IdWidth  writeback scoreboard ID.
- `wb_exception_o`  out  exception_t  writeback exception.
- `wb_src_o`  out  $clog2(NrSrc)  index of the granted channel.
- `occupancy_o`  out  NrSrc×$clog2(Depth+1)  per-channel fill level (performance counters).

## Operation
- Per-channel FIFO:
  - Push when `src_valid_i[i] & src_ready_o[i]`.
  - `src_ready_o[i] = ~full[i]`. Depends on state only, never on same-cycle pop.
  - Valid while not ready is dropped; an assertion flags it.
- Arbiter:
  - Request vector = `~empty`.
  - Round-robin pointer `last`. Search starts at `last+1` and wraps modulo `NrSrc`. The first requester wins.
  - Winner's head is popped and `last` ← winner.
  - `last` holds when there is no request.
- Output:
  - `wb_*` is driven combinationally from the granted head.
  - `wb_valid_o = |~empty`.
  - There is no output backpressure; the scoreboard always accepts.
  - When `wb_valid_o` = 0, `wb_result_o`, `wb_trans_id_o`, `wb_exception_o` and `wb_src_o` are 0 (data silencing).
- Simultaneous push and pop on the same channel: both happen and occupancy is unchanged. Legal only when not full at cycle start.
- Pointer wrap: read/write indices wrap at `Depth-1` → 0. Occupancy is tracked by a counter of `$clog2(Depth+1)` bits.
- `flush_i` or `clr_i`:
  - At the next edge, all FIFOs empty, occupancy 0, `last` ← NrSrc-1.
  - Pushes in that cycle are discarded.
  - `wb_valid_o` in the flush cycle still reflects pre-flush contents. Consumers gate it with flush.
- `exception_t.valid` is carried unmodified; the arbiter does not reorder within a channel (per-channel FIFO order is preserved).

## Timing
- Reset (`rst_ni` low, async):
  - All FIFOs empty and occupancy 0.
  - `last` = NrSrc-1, so channel 0 has first priority.
  - `wb_valid_o` = 0, `wb_*` = 0, `wb_src_o` = 0.
  - `src_ready_o` = all ones.
- Latency: push at edge t → visible on `wb_*` during cycle t+1 at the earliest (no bypass).
- Throughput: one writeback per cycle aggregate. A single channel sustains one per cycle when it is the only requester.
- Worst-case wait for a non-empty channel head: NrSrc-1 cycles.
- Reset asserted mid-operation discards all buffered entries immediately (asynchronous).

## Test plan
- Reset release, then channel 0 pushes result 0xA5, id 3 at cycle 0:
  - cycle 1: `wb_valid_o`=1, result 0xA5, id 3, `wb_src_o`=0.
  - cycle 2: `wb_valid_o`=0.
- All 4 channels push once in the same cycle (ids 0..3):
  - writebacks on consecutive cycles in order src 0,1,2,3.
  - `occupancy_o` decrements 1→0 per channel as it is granted.
- Fill channel 2 with Depth=2 pushes while channels 0,1 stream continuously:
  - `src_ready_o[2]`=0 after 2 pushes.
  - channel 2 is granted within 3 cycles.
  - `src_ready_o[2]` returns to 1 the cycle after its pop.
- Channel 1 holds 2 entries, `flush_i` pulses for one cycle while channel 3 pushes:
  - next cycle all occupancy 0 and `wb_valid_o`=0.
  - channel 3's push is lost.
  - the next push on any channel is granted starting from src 0.
- Exception propagation: channel 1 pushes with exception valid, cause 2:
  - output carries the identical exception_t.
  - entries behind it on channel 1 drain in order.
- Random stress with NrSrc=3, Depth=3, random valid/flush:
  - scoreboard model matches per-channel order.
  - no starvation beyond NrSrc-1 cycles.
  - no accepted entry is lost except by flush.
